i2s_tdm_clk_gen: RTL
====================

Name: i2s_tdm_clk_gen

Overview:
Master-mode serial clock and word-select generator for the transceiver, generalised from fixed stereo to NUM_CH-slot TDM frames. Divides the system clock into SCK and produces WS in stereo (level) or TDM (pulse) form for the I2S, MSB- and LSB-justified standards. It also supplies slot and bit position plus one-cycle edge strobes to the Tx/Rx shift logic. Configuration is shadowed and changes only at frame boundaries.

Parameters:
NUM_CH, 2, slots per frame (>=2); 2 = stereo level WS, >2 = TDM pulse WS
DIV_W, 8, width of clock divider setting

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  block enable; low = immediate synchronous return to idle
stop  in  1  request halt at next frame boundary
clk_div  in  DIV_W  SCK half-period minus 1, in clk cycles
slot_size  in  1  0 = 16-bit slots, 1 = 32-bit slots (frame_size encoding)
standard  in  2  00 = I2S, 01 = MSB, 10 = LSB, 11 = reserved
sck  out  1  serial clock
ws  out  1  word select / frame sync
sck_rise  out  1  1-cycle strobe in the cycle sck goes 0->1 (sample point)
sck_fall  out  1  1-cycle strobe in the cycle sck goes 1->0 (shift point)
ch_idx  out  $clog2(NUM_CH)  current slot index
bit_idx  out  5  bit within slot, counts SLOT-1 down to 0
frame_start  out  1  strobe with the sck_fall that begins slot 0, bit SLOT-1
idle  out  1  high when not generating clocks
cfg_err  out  1  sticky; set when reserved standard is latched, cleared by rst

Behaviour:
- Reset: sck=0, ws=0, all strobes 0, ch_idx=0, bit_idx=31, idle=1, cfg_err=0, divider and position counters 0.
- SLOT = 16 or 32 from the latched slot_size. FRAME = NUM_CH*SLOT. pos = ch_idx*SLOT + (SLOT-1-bit_idx), range 0..FRAME-1.
- Start: in idle, when en=1 and stop=0, latch clk_div/slot_size/standard into shadow regs, clear idle next cycle, pos=0, ws=ws_for(0), divider=0.
- Divider: counts 0..clk_div_shadow; on terminal count, sck toggles, divider returns to 0. SCK period = 2*(clk_div+1) clk cycles; clk_div=0 gives clk/2.
- First toggle after starting is a rise. Strobes assert in the same cycle the registered sck changes value.
- On each sck_fall except the first edge after start: pos advances by 1 mod FRAME, and ws <= ws_for(new pos). At the pos wrap to 0, frame_start=1.
- ws_for(p):
  - NUM_CH==2: MSB/LSB give (p >= SLOT); I2S gives ((p+1) mod FRAME >= SLOT), i.e. one SCK early. Left slot = ws 0.
  - NUM_CH>2: MSB/LSB give (p==0); I2S gives (p==FRAME-1), a one-SCK pulse preceding slot 0.
- Reserved standard (11): behaves as I2S; cfg_err set.
- Frame boundary = sck_fall where pos wraps to 0.
  - At the boundary, new config is re-latched.
  - If stop=1 at the boundary, halt instead: sck stays 0, ws=0, idle=1 the next cycle, no frame_start.
- en=0 at any time: next cycle all outputs return to reset values, except that cfg_err holds.
- Mid-frame changes of clk_div, slot_size or standard have no effect until the boundary.
- rst mid-operation forces reset values asynchronously; after release, restart requires en=1 and stop=0.
- stop and en rising in the same cycle while idle: remain idle.

Test Plan:
- NUM_CH=2, clk_div=1, slot=16, I2S: SCK period 4 clk; ws falls on the sck_fall at pos 31 and rises at pos 15; frame_start every 128 clk.
- Same settings with MSB standard: ws rises exactly at pos 16 and falls at pos 0; bit_idx runs 15..0 twice per frame.
- NUM_CH=8, slot=32, MSB: ws high only for pos 0; ch_idx 0..7 wraps; FRAME=256 SCK. With I2S, ws high only at pos 255.
- Change slot_size 0->1 at pos 5: frame completes with 16-bit slots, and the next frame uses 32-bit slots.
- Assert stop at pos 10: clocks continue to pos FRAME-1; then idle=1, sck=0, ws=0, and no frame_start.
- Assert rst mid-frame, and separately standard=11: the first forces all outputs to reset values immediately; the second sets cfg_err=1 with I2S timing, and cfg_err persists through en=0.

Source files
------------

// File: rtl/i2s_tdm_clk_gen.sv
// Master-mode SCK / WS generator for I2S, MSB- and LSB-justified stereo or NUM_CH-slot TDM frames.
// Configuration is shadowed at start and re-latched only at frame boundaries.
module i2s_tdm_clk_gen #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      stop,
    input  logic [DIV_W-1:0]          clk_div,
    input  logic                      slot_size,
    input  logic [1:0]                standard,
    output logic                      sck,
    output logic                      ws,
    output logic                      sck_rise,
    output logic                      sck_fall,
    output logic [$clog2(NUM_CH)-1:0] ch_idx,
    output logic [4:0]                bit_idx,
    output logic                      frame_start,
    output logic                      idle,
    output logic                      cfg_err
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int POS_W = $clog2(NUM_CH * 32) + 1;

    localparam logic [1:0] STD_MSB = 2'b01;
    localparam logic [1:0] STD_LSB = 2'b10;
    localparam logic [1:0] STD_RSV = 2'b11;

    logic             sck_q, sck_d;
    logic             ws_q, ws_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             fs_q, fs_d;
    logic             idle_q, idle_d;
    logic             cfg_err_q, cfg_err_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [4:0]       bit_q, bit_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_sh_q, div_sh_d;
    logic             slot_sh_q, slot_sh_d;
    logic [1:0]       std_sh_q, std_sh_d;

    logic             last_bit_s;
    logic             last_ch_s;
    logic [POS_W-1:0] pos_inc_s;

    function automatic logic [4:0] slot_top(input logic s32);
        return s32 ? 5'd31 : 5'd15;
    endfunction

    // Reserved standard falls through to the I2S branch.
    function automatic logic ws_for(input logic [POS_W-1:0] p, input logic s32, input logic [1:0] sd);
        logic [POS_W-1:0] slot;
        logic [POS_W-1:0] frame;
        logic [POS_W-1:0] nxt;
        logic             lvl;
        slot  = s32 ? POS_W'(32) : POS_W'(16);
        frame = POS_W'(NUM_CH) * slot;
        nxt   = (p == frame - POS_W'(1)) ? POS_W'(0) : p + POS_W'(1);
        if (NUM_CH == 2) begin
            if (sd == STD_MSB || sd == STD_LSB) lvl = (p >= slot);
            else                                lvl = (nxt >= slot);
        end else begin
            if (sd == STD_MSB || sd == STD_LSB) lvl = (p == POS_W'(0));
            else                                lvl = (p == frame - POS_W'(1));
        end
        return lvl;
    endfunction

    assign last_bit_s = (bit_q == 5'd0);
    assign last_ch_s  = (ch_q == CH_W'(NUM_CH - 1));
    assign pos_inc_s  = pos_q + POS_W'(1);

    // Next-state: enable/start handling, divider, SCK edges and frame position.
    always_comb begin
        sck_d     = sck_q;
        ws_d      = ws_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        fs_d      = 1'b0;
        idle_d    = idle_q;
        cfg_err_d = cfg_err_q;
        ch_d      = ch_q;
        bit_d     = bit_q;
        pos_d     = pos_q;
        cnt_d     = cnt_q;
        div_sh_d  = div_sh_q;
        slot_sh_d = slot_sh_q;
        std_sh_d  = std_sh_q;
        if (!en) begin
            sck_d     = 1'b0;
            ws_d      = 1'b0;
            idle_d    = 1'b1;
            ch_d      = CH_W'(0);
            bit_d     = 5'd31;
            pos_d     = POS_W'(0);
            cnt_d     = DIV_W'(0);
            div_sh_d  = DIV_W'(0);
            slot_sh_d = 1'b0;
            std_sh_d  = 2'b00;
        end else if (idle_q) begin
            if (!stop) begin
                idle_d    = 1'b0;
                div_sh_d  = clk_div;
                slot_sh_d = slot_size;
                std_sh_d  = standard;
                cfg_err_d = cfg_err_q | (standard == STD_RSV);
                cnt_d     = DIV_W'(0);
                sck_d     = 1'b0;
                pos_d     = POS_W'(0);
                ch_d      = CH_W'(0);
                bit_d     = slot_top(slot_size);
                ws_d      = ws_for(POS_W'(0), slot_size, standard);
            end else begin
                idle_d = 1'b1;
            end
        end else if (cnt_q != div_sh_q) begin
            cnt_d = cnt_q + DIV_W'(1);
        end else if (!sck_q) begin
            cnt_d  = DIV_W'(0);
            sck_d  = 1'b1;
            rise_d = 1'b1;
        end else begin
            cnt_d  = DIV_W'(0);
            sck_d  = 1'b0;
            fall_d = 1'b1;
            if (!last_bit_s) begin
                bit_d = bit_q - 5'd1;
                pos_d = pos_inc_s;
                ws_d  = ws_for(pos_inc_s, slot_sh_q, std_sh_q);
            end else if (!last_ch_s) begin
                ch_d  = ch_q + CH_W'(1);
                bit_d = slot_top(slot_sh_q);
                pos_d = pos_inc_s;
                ws_d  = ws_for(pos_inc_s, slot_sh_q, std_sh_q);
            end else if (stop) begin
                // Halt on the final falling edge; the frame is not restarted.
                idle_d = 1'b1;
                ws_d   = 1'b0;
                ch_d   = CH_W'(0);
                bit_d  = 5'd31;
                pos_d  = POS_W'(0);
            end else begin
                fs_d      = 1'b1;
                div_sh_d  = clk_div;
                slot_sh_d = slot_size;
                std_sh_d  = standard;
                cfg_err_d = cfg_err_q | (standard == STD_RSV);
                pos_d     = POS_W'(0);
                ch_d      = CH_W'(0);
                bit_d     = slot_top(slot_size);
                ws_d      = ws_for(POS_W'(0), slot_size, standard);
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q     <= 1'b0;
            ws_q      <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            fs_q      <= 1'b0;
            idle_q    <= 1'b1;
            cfg_err_q <= 1'b0;
            ch_q      <= CH_W'(0);
            bit_q     <= 5'd31;
            pos_q     <= POS_W'(0);
            cnt_q     <= DIV_W'(0);
            div_sh_q  <= DIV_W'(0);
            slot_sh_q <= 1'b0;
            std_sh_q  <= 2'b00;
        end else begin
            sck_q     <= sck_d;
            ws_q      <= ws_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            fs_q      <= fs_d;
            idle_q    <= idle_d;
            cfg_err_q <= cfg_err_d;
            ch_q      <= ch_d;
            bit_q     <= bit_d;
            pos_q     <= pos_d;
            cnt_q     <= cnt_d;
            div_sh_q  <= div_sh_d;
            slot_sh_q <= slot_sh_d;
            std_sh_q  <= std_sh_d;
        end
    end

    assign sck         = sck_q;
    assign ws          = ws_q;
    assign sck_rise    = rise_q;
    assign sck_fall    = fall_q;
    assign ch_idx      = ch_q;
    assign bit_idx     = bit_q;
    assign frame_start = fs_q;
    assign idle        = idle_q;
    assign cfg_err     = cfg_err_q;

endmodule
